// File: rtl/move_cmd_gen.sv
// Push-button front end for the 2048 move engine: sync, debounce, press arbitration, one-hot strobe + idle gap.
// Optional auto-repeat of a held direction is enabled by defining MOVE_AUTO_REPEAT_EN.
module move_cmd_gen #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20,
  parameter int PULSE_CYCLES    = 4,
  parameter int GAP_CYCLES      = 16,
  parameter int REPEAT_CYCLES   = 50000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  btn_raw,
  input  logic        over,
  input  logic        success,
  output logic [3:0]  btn,
  output logic        busy,
  output logic [1:0]  last_dir,
  output logic [15:0] move_count
);

  localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

  logic [3:0]       sync_p0, sync_p1;
  logic [3:0]       lvl_p2, lvl_p3, press_p3;
  logic [CNT_W-1:0] db_cnt [4];

  state_t           state, state_n;
  logic [CNT_W-1:0] tmr, tmr_n;
  logic [3:0]       btn_n;
  logic [1:0]       last_dir_n;
  logic [15:0]      count_n;
  logic [1:0]       sel_idx;
  logic             sel_ok;
  logic             rep_req;
  logic [1:0]       rep_dir;

  // Stage p0/p1: two-flop synchronizer
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= btn_raw;
      sync_p1 <= sync_p0;
    end
  end

  // Stage p2: per-bit debounce; level flips after DEBOUNCE_CYCLES consecutive disagreeing samples
  always_ff @(posedge clk) begin
    if (rst) begin
      lvl_p2 <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync_p1[i] == lvl_p2[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          lvl_p2[i] <= ~lvl_p2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Stage p3: registered one-cycle rising edge of the debounced level
  always_ff @(posedge clk) begin
    if (rst) begin
      lvl_p3   <= '0;
      press_p3 <= '0;
    end else begin
      lvl_p3   <= lvl_p2;
      press_p3 <= lvl_p2 & ~lvl_p3;
    end
  end

`ifdef MOVE_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 2);

  logic [CNT_W-1:0] rep_cnt;
  logic             rep_on;
  logic             rep_due;
  logic             issue;

  assign issue   = (state == IDLE) && (state_n == PULSE);
  assign rep_req = rep_due;

  // Repeat timer restarts on every issued strobe; becomes due REPEAT_CYCLES edges later
  always_ff @(posedge clk) begin
    if (rst) begin
      rep_on  <= 1'b0;
      rep_due <= 1'b0;
      rep_cnt <= '0;
      rep_dir <= 2'd0;
    end else if (issue) begin
      rep_on  <= 1'b1;
      rep_due <= 1'b0;
      rep_cnt <= '0;
      rep_dir <= last_dir_n;
    end else if (rep_on && (!lvl_p2[rep_dir] || (|press_p3))) begin
      rep_on  <= 1'b0;
      rep_due <= 1'b0;
    end else if (rep_on && !rep_due) begin
      if (rep_cnt == REP_LAST) rep_due <= 1'b1;
      else                     rep_cnt <= rep_cnt + 1'b1;
    end
  end
`else
  assign rep_req = 1'b0;
  assign rep_dir = 2'd0;
`endif

  always_comb begin
    state_n    = state;
    tmr_n      = tmr;
    btn_n      = btn;
    last_dir_n = last_dir;
    count_n    = move_count;
    sel_idx    = 2'd0;
    sel_ok     = 1'b0;
    // Descending scan leaves the lowest-index (highest-priority) press selected
    for (int i = 3; i >= 0; i--) begin
      if (press_p3[i]) begin
        sel_idx = 2'(i);
        sel_ok  = 1'b1;
      end
    end
    if (!sel_ok && rep_req) begin
      sel_idx = rep_dir;
      sel_ok  = 1'b1;
    end
    case (state)
      IDLE: begin
        btn_n = 4'b0000;
        if (sel_ok && !(over || success)) begin
          state_n    = PULSE;
          tmr_n      = '0;
          btn_n      = 4'b0001 << sel_idx;
          last_dir_n = sel_idx;
          count_n    = move_count + 16'd1;
        end
      end
      PULSE: begin
        if (tmr == PULSE_LAST) begin
          state_n = GAP;
          tmr_n   = '0;
          btn_n   = 4'b0000;
        end else begin
          tmr_n = tmr + 1'b1;
        end
      end
      GAP: begin
        btn_n = 4'b0000;
        if (tmr == GAP_LAST) state_n = IDLE;
        else                 tmr_n   = tmr + 1'b1;
      end
      default: begin
        state_n = IDLE;
        btn_n   = 4'b0000;
      end
    endcase
  end

  // Stage p4: strobe outputs registered together with the state
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tmr        <= '0;
      btn        <= 4'b0000;
      busy       <= 1'b0;
      last_dir   <= 2'd0;
      move_count <= 16'd0;
    end else begin
      state      <= state_n;
      tmr        <= tmr_n;
      btn        <= btn_n;
      busy       <= (state_n != IDLE);
      last_dir   <= last_dir_n;
      move_count <= count_n;
    end
  end

endmodule

// File: tb/tb_move_cmd_gen.sv
// Scoreboard bench for move_cmd_gen: stimulus queues expected strobes, a negedge monitor checks them.
module tb_move_cmd_gen;

  localparam int D = 4;
  localparam int P = 2;
  localparam int G = 3;
  localparam int R = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  btn_raw;
  logic        over;
  logic        success;
  logic [3:0]  btn;
  logic        busy;
  logic [1:0]  last_dir;
  logic [15:0] move_count;

  typedef struct {
    logic [3:0] b;
    int         dir;
    int         cnt;
    int         at;
  } exp_t;

  exp_t sb[$];
  int   total_cnt = 0;
  int   pass_cnt  = 0;
  int   cyc       = 0;
  int   exp_count = 0;
  bit   started   = 1'b0;

  move_cmd_gen #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W(8),
    .PULSE_CYCLES(P),
    .GAP_CYCLES(G),
    .REPEAT_CYCLES(R)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_raw(btn_raw),
    .over(over),
    .success(success),
    .btn(btn),
    .busy(busy),
    .last_dir(last_dir),
    .move_count(move_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d required below 20000", cyc);
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_strobe(input logic [3:0] b, input int dir, input int at);
    exp_t e;
    exp_count = (exp_count + 1) % 65536;
    e.b = b; e.dir = dir; e.cnt = exp_count; e.at = at;
    sb.push_back(e);
  endtask

  task automatic wait_btn(input logic [3:0] want, input string name);
    int n = 0;
    while (btn !== want && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(name, int'(btn), int'(want));
  endtask

  // Monitor: pops one expectation per strobe, measures strobe and gap widths
  bit         in_pulse = 1'b0;
  bit         in_gap   = 1'b0;
  int         width    = 0;
  int         gap      = 0;
  logic [3:0] cur      = 4'b0000;

  always @(negedge clk) begin
    exp_t e;
    if (!started || rst) begin
      in_pulse = 1'b0;
      in_gap   = 1'b0;
      width    = 0;
      gap      = 0;
    end else if (btn != 4'b0000) begin
      if (!in_pulse) begin
        check("strobe_onehot", int'($onehot(btn)), 1);
        if (sb.size() == 0) begin
          check("unexpected_strobe", int'(btn), 0);
        end else begin
          e = sb.pop_front();
          check("strobe_btn", int'(btn), int'(e.b));
          check("strobe_last_dir", int'(last_dir), e.dir);
          check("strobe_move_count", int'(move_count), e.cnt);
          check("strobe_busy", int'(busy), 1);
          check("strobe_cycle", cyc, e.at);
        end
        in_pulse = 1'b1;
        in_gap   = 1'b0;
        width    = 1;
        cur      = btn;
      end else begin
        width++;
        if (btn != cur) check("strobe_stable", int'(btn), int'(cur));
      end
    end else if (in_pulse) begin
      check("pulse_width", width, P);
      in_pulse = 1'b0;
      in_gap   = 1'b1;
      gap      = busy ? 1 : 0;
    end else if (in_gap) begin
      if (busy) begin
        gap++;
      end else begin
        check("gap_width", gap, G);
        in_gap = 1'b0;
      end
    end
  end

  initial begin
    int base;
    rst = 1'b1; btn_raw = 4'b0000; over = 1'b0; success = 1'b0;
    tick(3);
    check("rst_btn", int'(btn), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_last_dir", int'(last_dir), 0);
    check("rst_move_count", int'(move_count), 0);
    rst = 1'b0;
    started = 1'b1;
    tick(5);

    // clean press right
    expect_strobe(4'b0001, 0, cyc + D + 4);
    btn_raw = 4'b0001; tick(10); btn_raw = 4'b0000; tick(20);
    check("clean_count", int'(move_count), 1);

    // bouncing up button never qualifies
    for (int k = 0; k < 3; k++) begin
      btn_raw = 4'b0100; tick(2);
      btn_raw = 4'b0000; tick(2);
    end
    tick(20);
    check("bounce_count", int'(move_count), 1);

    // simultaneous left+down: left wins
    expect_strobe(4'b0010, 1, cyc + D + 4);
    btn_raw = 4'b1010; tick(10); btn_raw = 4'b0000; tick(20);
    check("simul_count", int'(move_count), 2);

    // down pressed while the up strobe is in flight is dropped
    expect_strobe(4'b0100, 2, cyc + D + 4);
    btn_raw = 4'b0100; tick(2);
    btn_raw = 4'b1100; tick(12);
    btn_raw = 4'b0000; tick(20);
    check("busy_drop_count", int'(move_count), 3);

    // lockout by over, then accepted once cleared
    over = 1'b1;
    btn_raw = 4'b0001; tick(10); btn_raw = 4'b0000; tick(20);
    check("lockout_count", int'(move_count), 3);
    over = 1'b0; tick(2);
    expect_strobe(4'b0001, 0, cyc + D + 4);
    btn_raw = 4'b0001; tick(10); btn_raw = 4'b0000; tick(20);
    check("unlock_count", int'(move_count), 4);

    // success rising mid-PULSE does not truncate the strobe
    expect_strobe(4'b0010, 1, cyc + D + 4);
    btn_raw = 4'b0010;
    wait_btn(4'b0010, "success_wait_strobe");
    success = 1'b1; tick(2);
    btn_raw = 4'b0000; tick(8);
    success = 1'b0; tick(15);
    check("success_count", int'(move_count), 5);

    // hold left for 60 cycles
    base = cyc;
    expect_strobe(4'b0010, 1, base + D + 4);
`ifdef MOVE_AUTO_REPEAT_EN
    expect_strobe(4'b0010, 1, base + D + 4 + R);
    expect_strobe(4'b0010, 1, base + D + 4 + 2 * R);
`endif
    btn_raw = 4'b0010; tick(60); btn_raw = 4'b0000; tick(30);
`ifdef MOVE_AUTO_REPEAT_EN
    check("hold_count", int'(move_count), 8);
`else
    check("hold_count", int'(move_count), 6);
`endif

    // reset during the down strobe
    expect_strobe(4'b1000, 3, cyc + D + 4);
    btn_raw = 4'b1000;
    wait_btn(4'b1000, "reset_wait_strobe");
    @(posedge clk);
    #2 rst = 1'b1;
    btn_raw = 4'b0000;
    @(posedge clk);
    #1;
    check("rstmid_btn", int'(btn), 0);
    check("rstmid_move_count", int'(move_count), 0);
    check("rstmid_last_dir", int'(last_dir), 0);
    check("rstmid_busy", int'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    exp_count = 0;
    tick(5);

    // counting restarts after reset
    expect_strobe(4'b0100, 2, cyc + D + 4);
    btn_raw = 4'b0100; tick(10); btn_raw = 4'b0000; tick(20);
    check("post_reset_count", int'(move_count), 1);

    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
